// File: rtl/add_serial.sv
// Bit-serial unsigned adder, LSB first; done pulses WIDTH cycles after an accepted start.
// No backpressure: start is only sampled in IDLE/DONE, and start while busy is dropped.
module add_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             c_q;
    logic             accept;
    logic             last_bit;
    logic             fa_s, fa_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign last_bit = (idx == IW'(WIDTH - 1));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // The single full-adder cell shared by every bit position.
    assign fa_s = a_q[idx] ^ b_q[idx] ^ c_q;
    assign fa_c = (a_q[idx] & b_q[idx]) | (a_q[idx] & c_q) | (b_q[idx] & c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            c_q   <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
            idx <= '0;
            c_q <= 1'b0;
            sum <= '0;
        end else if (state == ST_RUN) begin
            sum[idx] <= fa_s;
            c_q      <= fa_c;
            if (last_bit) begin
                carry <= fa_c;
                idx   <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial (WIDTH=8): arithmetic, latency, handshake and reset cases.
module tb_add_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] sum;
    logic       carry;

    int total = 0;
    int bad   = 0;

    add_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start pulse and waits (bounded) for done; no checking here.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] osum, output logic ocarry,
                          output int lat, output int busy_cnt);
        @(posedge clk); #1;
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        lat = 0; busy_cnt = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        osum = sum; ocarry = carry;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = 8'h5A; b = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, sum, carry} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h carry=%b, want all 0", busy, done, sum, carry);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        logic [7:0] ia [3] = '{8'd3, 8'd200, 8'd255};
        logic [7:0] ib [3] = '{8'd5, 8'd100, 8'd1};
        logic [7:0] es [3] = '{8'd8, 8'd44, 8'd0};
        logic       ec [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] s;
        logic       c;
        int         lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(ia[i], ib[i], s, c, lat, bc);
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want 8", i, lat);
            end
            total++;
            if (bc !== 8) begin
                bad++;
                $display("FAIL basic_busy_cycles[%0d]: got %0d, want 8", i, bc);
            end
            total++;
            if (s !== es[i] || c !== ec[i]) begin
                bad++;
                $display("FAIL basic_sum[%0d]: got sum=%0d carry=%b, want sum=%0d carry=%b", i, s, c, es[i], ec[i]);
            end
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || sum !== es[i]) begin
                bad++;
                $display("FAIL basic_done_pulse[%0d]: got done=%b sum=%0d, want done=0 sum=%0d", i, done, sum, es[i]);
            end
        end
    endtask

    task automatic test_roundtrip;
        logic [7:0] s, d;
        logic       c;
        int         lat, bc;
        for (int x = 0; x <= 126; x += 5) begin
            for (int y = 0; y <= 126; y += 7) begin
                d = 8'(x - y);
                run_op(d, 8'(y), s, c, lat, bc);
                @(posedge clk); #1;
                total++;
                if (s !== 8'(x) || lat !== 8 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL roundtrip x=%0d y=%0d: got sum=%0d lat=%0d done_after=%b, want sum=%0d lat=8 done_after=0",
                             x, y, s, lat, done, x);
                end
            end
        end
    endtask

    task automatic test_ignore_busy;
        int lat;
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 8 || sum !== 8'h46 || carry !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_busy: got lat=%0d sum=%h carry=%b, want lat=8 sum=46 carry=0", lat, sum, carry);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_requeue: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] s;
        logic       c;
        int         lat, bc, seen;
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h1F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, carry} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset_mid_run: got busy=%b done=%b sum=%h carry=%b, want all 0", busy, done, sum, carry);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL no_done_after_reset: got %0d active cycles, want 0", seen);
        end
        run_op(8'd7, 8'd9, s, c, lat, bc);
        total++;
        if (s !== 8'd16 || c !== 1'b0 || lat !== 8) begin
            bad++;
            $display("FAIL op_after_reset: got sum=%0d carry=%b lat=%0d, want 16 0 8", s, c, lat);
        end
    endtask

    task automatic test_back_to_back;
        int errs = 0;
        int pulses = 0;
        @(posedge clk); #1;
        a = 8'd1; b = 8'd1; start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (done !== ((cyc % 9) == 0) || busy !== ((cyc % 9) != 0)) begin
                errs++;
                $display("FAIL b2b_handshake cyc=%0d: got busy=%b done=%b, want busy=%b done=%b",
                         cyc, busy, done, (cyc % 9) != 0, (cyc % 9) == 0);
            end
            if (done) begin
                pulses++;
                if (sum !== 8'd2 || carry !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_sum cyc=%0d: got sum=%0d carry=%b, want 2 0", cyc, sum, carry);
                end
            end
        end
        start = 1'b0;
        total++;
        if (errs !== 0) bad++;
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL b2b_pulse_count: got %0d, want 3", pulses);
        end
        repeat (10) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_roundtrip();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
